// File: rtl/step_seq_pkg.sv
// Shared definitions for the DAC/ADC characterisation sweep controller:
// state encoding and default sweep/settle parameters.
package step_seq_pkg;

  localparam int NSTEPS_DEF = 92;
  localparam int SETTLE_DEF = 5000;
  localparam int SETTLE_W   = 16;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_DAC_REQ  = 4'd1,
    ST_DAC_WAIT = 4'd2,
    ST_SETTLE   = 4'd3,
    ST_ADC_REQ  = 4'd4,
    ST_ADC_WAIT = 4'd5,
    ST_TX_REQ   = 4'd6,
    ST_TX_WAIT  = 4'd7,
    ST_NEXT     = 4'd8
  } state_t;

endpackage

// File: rtl/step_sequencer_settle_timer.sv
// Clearable, enabled up-counter that flags when it sits on a programmable
// terminal value. Clear has priority over enable.
module settle_timer
  import step_seq_pkg::*;
#(
  parameter int W = SETTLE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] last_count,
  output logic         terminal
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + W'(1);
    end
  end

  assign terminal = (count == last_count);

endmodule

// File: rtl/step_sequencer.sv
// Sweep controller: walks the voltage-ROM address and, for each step, runs
// DAC write -> settle -> ADC conversion -> UART transmit via start/done handshakes.
module step_sequencer
  import step_seq_pkg::*;
#(
  parameter int NSTEPS        = NSTEPS_DEF,
  parameter int AW            = 8,
  parameter int SETTLE_CYCLES = SETTLE_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  output logic [AW-1:0] addr_o,
  output logic          dac_start_o,
  input  logic          dac_done_i,
  output logic          adc_start_o,
  input  logic          adc_done_i,
  output logic          tx_start_o,
  input  logic          tx_done_i,
  output logic          busy_o,
  output logic          done_o
);

  localparam logic [AW-1:0]       LAST_ADDR   = AW'(NSTEPS - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  state_t state;
  logic   settle_done;

  // Counter is held at zero outside SETTLE, so every settle period starts from 0.
  settle_timer #(
    .W(SETTLE_W)
  ) u_settle_timer (
    .clk        (clk_i),
    .rst        (rst_i),
    .clear      (state != ST_SETTLE),
    .enable     (state == ST_SETTLE),
    .last_count (SETTLE_LAST),
    .terminal   (settle_done)
  );

  // Outputs are set on the transition into the state they belong to, so each
  // start pulse and done_o coincide exactly with their state and are registered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      addr_o      <= '0;
      dac_start_o <= 1'b0;
      adc_start_o <= 1'b0;
      tx_start_o  <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      dac_start_o <= 1'b0;
      adc_start_o <= 1'b0;
      tx_start_o  <= 1'b0;
      done_o      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            state       <= ST_DAC_REQ;
            addr_o      <= '0;
            dac_start_o <= 1'b1;
            busy_o      <= 1'b1;
          end
        end
        ST_DAC_REQ: state <= ST_DAC_WAIT;
        ST_DAC_WAIT: begin
          if (dac_done_i) state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_done) begin
            state       <= ST_ADC_REQ;
            adc_start_o <= 1'b1;
          end
        end
        ST_ADC_REQ: state <= ST_ADC_WAIT;
        ST_ADC_WAIT: begin
          if (adc_done_i) begin
            state      <= ST_TX_REQ;
            tx_start_o <= 1'b1;
          end
        end
        ST_TX_REQ: state <= ST_TX_WAIT;
        ST_TX_WAIT: begin
          if (tx_done_i) begin
            state  <= ST_NEXT;
            done_o <= (addr_o == LAST_ADDR);
          end
        end
        ST_NEXT: begin
          if (addr_o == LAST_ADDR) begin
            state  <= ST_IDLE;
            addr_o <= '0;
            busy_o <= 1'b0;
          end else begin
            state       <= ST_DAC_REQ;
            addr_o      <= addr_o + AW'(1);
            dac_start_o <= 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          addr_o <= '0;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/step_sequencer.md
# step_sequencer

Sweep controller for the 92-step DAC/ADC characterisation run. It walks the voltage-ROM address from 0 to NSTEPS-1. At each step it:
- requests a DAC write of the ROM code,
- waits a fixed settle time,
- triggers one ADC conversion,
- triggers one UART transmission of the result.

It sits directly upstream of the voltage ROM (drives its address) and orchestrates the DAC SPI driver, ADC SPI driver and TX block through start/done handshakes.

## Interface
- NSTEPS, 92, number of sweep points; last address is NSTEPS-1
- AW, 8, address width; must satisfy 2^AW >= NSTEPS
- SETTLE_CYCLES, 5000, DAC settle wait in clk cycles (100 us at 50 MHz); legal range 1..65535
- clk_i  in  1  system clock
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  begin sweep; sampled only in IDLE
- addr_o  out  AW  ROM address / current step index
- dac_start_o  out  1  one-cycle request to DAC driver
- dac_done_i  in  1  DAC driver completion pulse
- adc_start_o  out  1  one-cycle request to ADC driver
- adc_done_i  in  1  ADC conversion completion pulse
- tx_start_o  out  1  one-cycle request to TX block
- tx_done_i  in  1  TX completion pulse
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse on sweep completion

## Operation
- States: IDLE, DAC_REQ, DAC_WAIT, SETTLE, ADC_REQ, ADC_WAIT, TX_REQ, TX_WAIT, NEXT.
- IDLE: start_i=1 -> DAC_REQ with addr_o=0.
- DAC_REQ: dac_start_o=1 for exactly this one cycle -> DAC_WAIT.
- DAC_WAIT: dac_done_i=1 -> SETTLE with settle counter cleared; otherwise hold.
- SETTLE: lasts exactly SETTLE_CYCLES cycles -> ADC_REQ.
- ADC_REQ: adc_start_o=1 for one cycle -> ADC_WAIT. ADC_WAIT: adc_done_i=1 -> TX_REQ.
- TX_REQ: tx_start_o=1 for one cycle -> TX_WAIT. TX_WAIT: tx_done_i=1 -> NEXT.
- NEXT, addr_o < NSTEPS-1: addr_o increments -> DAC_REQ.
- NEXT, addr_o == NSTEPS-1: done_o=1 this cycle; addr_o clears to 0 -> IDLE.
- done_i inputs are honoured only in their own WAIT state. Pulses arriving in any other state, including the REQ cycle, are ignored.
- start_i while busy is ignored. No abort input; rst_i is the only way to terminate a sweep.
- addr_o is stable from DAC_REQ through NEXT of each step, so the ROM output is valid for the whole DAC transaction.
- No wrap past NSTEPS-1; addr_o never reaches NSTEPS.

## Timing
- Reset values: state IDLE, addr_o=0, all *_start_o=0, busy_o=0, done_o=0, settle counter=0.
- All outputs are registered or decoded from the registered state; no combinational path from any input to any output.
- start_i high in cycle 0 -> DAC_REQ (dac_start_o=1, busy_o=1) in cycle 1.
- Minimum step length, with each done arriving in the first WAIT cycle: SETTLE_CYCLES+7 cycles (DAC_REQ through NEXT inclusive).
- Settle counter: 16-bit, counts 0..SETTLE_CYCLES-1 in SETTLE; exit is on terminal count.
- rst_i asserted mid-sweep: immediate (asynchronous) return to reset values. The sweep restarts only on a new start_i.
- Simultaneous done_i pulses from several clients: only the one matching the current WAIT state has effect.

## Structure
- Shared package step_seq_pkg holds:
  - the state enumeration, 4-bit binary encoding,
  - NSTEPS_DEF=92, SETTLE_DEF=5000, SETTLE_W=16.
- One sub-module, settle_timer: clear/enable/terminal-count counter of width SETTLE_W, reused by later projects.
- The ROM is instantiated at top level alongside this block, not inside it.

## Test plan
Bench uses SETTLE_CYCLES=4; each done responder pulses 1 cycle after the corresponding start unless stated.
- Reset then idle 20 cycles -> all outputs 0, addr_o=0, no start pulses.
- start_i pulse at cycle 0 -> dac_start_o at cycle 1, adc_start_o at cycle 7, tx_start_o at cycle 9, addr_o=1 at cycle 12.
- Full sweep -> exactly 92 each of dac/adc/tx start pulses; addr_o sequence 0..91; done_o single pulse at cycle 1012; then busy_o=0, addr_o=0.
- DAC responder delays done 50 cycles; spurious adc_done_i during SETTLE -> SETTLE still lasts 4 cycles; spurious pulse ignored; adc_start_o 4 cycles after DAC_WAIT exit.
- start_i re-pulsed at step 10 -> no effect; sweep continues uninterrupted.
- rst_i asserted while in ADC_WAIT at addr 37 -> outputs return to reset values asynchronously; next start_i begins again at addr_o=0.
